gf2m_mul_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one digit-serial GF(2^m) multiplier (external instance, `start`/`done` handshake) among N_REQ requesters. Accepts one request at a time, latches its operands, issues a one-cycle start pulse, waits for done, then returns the product to the granted requester. Sits between the ROLLO polynomial/syndrome engines and the single multiplier instance.

---
 rtl/gf2m_mul_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_gf2m_mul_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gf2m_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : gf2m_mul_arbiter
// Description : Round-robin arbiter and sequencer that shares one external
//               digit-serial GF(2^m) multiplier among N_REQ requesters.
//               One request is accepted at a time. Its operands are latched,
//               a one-cycle start pulse is issued, and the sequencer waits
//               for done. The product is then returned to the requester that
//               was granted.
//
// Parameters  : WIDTH   - field degree m, operand/result width
//               N_REQ   - number of requesters (2..8)
//               TIMEOUT - max BUSY cycles before abort (present only when
//                         GF2M_ARB_TIMEOUT_EN is defined)
//
// Ports       : clk, rst_b            clock, async active-low reset
//               req/req_op_a/req_op_b requester levels and packed operands
//               gnt                   one-hot grant (comb, IDLE only)
//               resp_valid/resp_data  one-hot response pulse + product
//               resp_err              response is a timeout abort
//               busy                  sequencer not in IDLE
//               mul_start/op_a/op_b   multiplier launch interface
//               mul_done/mul_op_c     multiplier completion interface
//
// Optional    : `define GF2M_ARB_TIMEOUT_EN enables the BUSY watchdog;
//               without it, BUSY waits forever and resp_err is tied 0.
//
// Revision    : 1.0 - initial release
// ============================================================================
module gf2m_mul_arbiter #(
    parameter int WIDTH   = 127,
    parameter int N_REQ   = 4
`ifdef GF2M_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 64
`endif
) (
    input  logic                   clk,
    input  logic                   rst_b,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] req_op_a,
    input  logic [N_REQ*WIDTH-1:0] req_op_b,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       resp_valid,
    output logic [WIDTH-1:0]       resp_data,
    output logic                   resp_err,
    output logic                   busy,
    output logic                   mul_start,
    output logic [WIDTH-1:0]       mul_op_a,
    output logic [WIDTH-1:0]       mul_op_b,
    input  logic                   mul_done,
    input  logic [WIDTH-1:0]       mul_op_c
);

    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_BUSY  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [WIDTH-1:0] resp_data_q, resp_data_d;

    logic [ID_W-1:0]  sel;
    logic [ID_W-1:0]  cand;
    logic             found;
    int               idx;
    logic [WIDTH-1:0] sel_op_a, sel_op_b;

`ifdef GF2M_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
`endif

    // Round-robin pick: first requester at or above ptr, wrapping modulo
    // N_REQ. ptr always points one past the last served id, so the id that
    // was just served becomes the lowest priority.
    always_comb begin
        sel   = ptr_q;
        found = 1'b0;
        idx   = 0;
        cand  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx  = (int'(ptr_q) + k) % N_REQ;
            cand = ID_W'(idx);
            if (!found && req[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    // Operand mux for the selected requester.
    always_comb begin
        sel_op_a = '0;
        sel_op_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (sel == ID_W'(i)) begin
                sel_op_a = req_op_a[i*WIDTH +: WIDTH];
                sel_op_b = req_op_b[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        resp_data_d = resp_data_q;
`ifdef GF2M_ARB_TIMEOUT_EN
        cnt_d       = cnt_q;
        err_d       = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    id_d    = sel;
                    op_a_d  = sel_op_a;
                    op_b_d  = sel_op_b;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
`ifdef GF2M_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
                state_d = S_BUSY;
            end
            S_BUSY: begin
                // A done arriving in the expiry cycle takes priority over
                // the abort, so a late but valid product is never dropped.
                if (mul_done) begin
                    resp_data_d = mul_op_c;
`ifdef GF2M_ARB_TIMEOUT_EN
                    err_d       = 1'b0;
`endif
                    state_d     = S_RESP;
                end
`ifdef GF2M_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    resp_data_d = '0;
                    err_d       = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            S_RESP: begin
                ptr_d   = (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            id_q        <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            resp_data_q <= '0;
`ifdef GF2M_ARB_TIMEOUT_EN
            cnt_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            resp_data_q <= resp_data_d;
`ifdef GF2M_ARB_TIMEOUT_EN
            cnt_q       <= cnt_d;
            err_q       <= err_d;
`endif
        end
    end

    // gnt is combinational from req; it is gated with rst_b so that a
    // requester never sees a grant that the held-in-reset flops cannot take.
    assign gnt        = (rst_b && (state_q == S_IDLE) && found) ?
                        (N_REQ'(1) << sel) : '0;
    assign resp_valid = (state_q == S_RESP) ? (N_REQ'(1) << id_q) : '0;
    assign resp_data  = resp_data_q;
    assign busy       = (state_q != S_IDLE);
    assign mul_start  = (state_q == S_ISSUE);
    assign mul_op_a   = op_a_q;
    assign mul_op_b   = op_b_q;
`ifdef GF2M_ARB_TIMEOUT_EN
    assign resp_err   = err_q;
`else
    assign resp_err   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gf2m_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_gf2m_mul_arbiter
// Description : Self-checking bench for gf2m_mul_arbiter. A behavioural
//               multiplier stand-in answers mul_start with done three cycles
//               later. Expected products are hand-computed constants for
//               f(x) = x^127 + x + 1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gf2m_mul_arbiter;

    localparam int W = 127;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_b;
    logic [N-1:0]   req;
    logic [N*W-1:0] op_a, op_b;
    logic [N-1:0]   gnt, resp_valid;
    logic [W-1:0]   resp_data, mul_op_a, mul_op_b, mul_op_c;
    logic           resp_err, busy, mul_start, mul_done;

    logic           done_en;
    logic           spur;
    logic [2:0]     pipe;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    gf2m_mul_arbiter #(
        .WIDTH(W),
        .N_REQ(N)
`ifdef GF2M_ARB_TIMEOUT_EN
        ,
        .TIMEOUT(8)
`endif
    ) dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .req       (req),
        .req_op_a  (op_a),
        .req_op_b  (op_b),
        .gnt       (gnt),
        .resp_valid(resp_valid),
        .resp_data (resp_data),
        .resp_err  (resp_err),
        .busy      (busy),
        .mul_start (mul_start),
        .mul_op_a  (mul_op_a),
        .mul_op_b  (mul_op_b),
        .mul_done  (mul_done),
        .mul_op_c  (mul_op_c)
    );

    // Multiplier stand-in: start in cycle S -> done in cycle S+3.
    function automatic logic [W-1:0] gf_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r, t;
        r = '0;
        t = a;
        for (int i = 0; i < W; i++) begin
            if (b[i]) r = r ^ t;
            t = t[W-1] ? ((t << 1) ^ W'(3)) : (t << 1);
        end
        return r;
    endfunction

    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) pipe <= '0;
        else        pipe <= {pipe[1:0], mul_start};
    end
    assign mul_done = (pipe[2] & done_en) | spur;
    assign mul_op_c = gf_mul(mul_op_a, mul_op_b);

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, " gnt"},        gnt,        '0);
        chk({tag, " resp_valid"}, resp_valid, '0);
        chk({tag, " resp_err"},   resp_err,   '0);
        chk({tag, " busy"},       busy,       '0);
        chk({tag, " mul_start"},  mul_start,  '0);
        chk({tag, " mul_op_a"},   mul_op_a,   '0);
        chk({tag, " mul_op_b"},   mul_op_b,   '0);
        chk({tag, " resp_data"},  resp_data,  '0);
    endtask

    task automatic do_reset();
        req   = '0;
        rst_b = 1'b0;
        step();
        step();
        rst_b = 1'b1;
        step();
    endtask

    // Waits (bounded) for a grant, then counts cycles from grant to response.
    task automatic serve(input string tag, input int who, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] exp_d,
                         input bit drop, input int exp_lat, input bit exp_err);
        int waited;
        int lat;
        logic [N-1:0] g;
        #1;
        waited = 0;
        while (gnt == '0 && waited < 20) begin
            step();
            waited++;
        end
        g = gnt;
        chk({tag, " gnt"}, g, W'(N'(1) << who));
        lat = 0;
        while (lat < 40) begin
            step();
            lat++;
            if (lat == 1) begin
                if (drop) req = '0;
                chk({tag, " mul_start"}, mul_start, 1'b1);
                chk({tag, " mul_op_a"},  mul_op_a,  a);
                chk({tag, " mul_op_b"},  mul_op_b,  b);
            end
            if (resp_valid != '0) break;
        end
        chk({tag, " latency"},    lat,        exp_lat);
        chk({tag, " resp_valid"}, resp_valid, W'(N'(1) << who));
        chk({tag, " resp_data"},  resp_data,  exp_d);
        chk({tag, " resp_err"},   resp_err,   exp_err);
    endtask

    typedef struct {
        int         who;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] p;
    } vec_t;

    vec_t vt[7];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] saved;
        logic         seen;

        // x^126*x = x+1; x^128 = x^2+x; x^252 = x^126+x^125
        vt[0] = '{0, W'(1) << 126, W'(2),           W'(3)};
        vt[1] = '{1, W'(1),        W'(48'h123456789abc), W'(48'h123456789abc)};
        vt[2] = '{2, W'(2),        W'(2),           W'(4)};
        vt[3] = '{3, W'(1) << 64,  W'(1) << 64,     W'(6)};
        vt[4] = '{0, W'(3),        W'(3),           W'(5)};
        vt[5] = '{1, W'(0),        {W{1'b1}},       W'(0)};
        vt[6] = '{2, W'(1) << 126, W'(1) << 126,    (W'(1) << 126) | (W'(1) << 125)};

        rst_b   = 1'b0;
        req     = '0;
        op_a    = '0;
        op_b    = '0;
        done_en = 1'b1;
        spur    = 1'b0;
        step();
        step();
        chk_zero_outputs("reset");
        req = 4'b0001;
        #1;
        chk("reset gnt_gated", gnt, '0);
        req = '0;
        rst_b = 1'b1;
        step();

        // Directed single-requester vectors.
        for (int i = 0; i < 7; i++) begin
            op_a = '0;
            op_b = '0;
            op_a[vt[i].who*W +: W] = vt[i].a;
            op_b[vt[i].who*W +: W] = vt[i].b;
            req = N'(1) << vt[i].who;
            serve($sformatf("vec%0d", i), vt[i].who, vt[i].a, vt[i].b, vt[i].p, 1'b1, 5, 1'b0);
        end

        // Spurious done in IDLE must not produce a response.
        step();
        saved = resp_data;
        spur  = 1'b1;
        step();
        spur  = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (resp_valid != '0 || busy) seen = 1'b1;
        end
        chk("spurious no_resp", seen, 1'b0);
        chk("spurious resp_data_held", resp_data, saved);

        // Contention with all four held from ptr=0: grants 0,1,2,3,0.
        do_reset();
        for (int i = 0; i < N; i++) begin
            op_a[i*W +: W] = W'(1) << 126;
            op_b[i*W +: W] = W'(1) << (i + 1);
        end
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            serve($sformatf("cont%0d", n), n % N, W'(1) << 126, W'(1) << ((n % N) + 1),
                  W'(3) << (n % N), 1'b0, 5, 1'b0);
        end
        req = '0;

        // Fairness: req[0] and req[2] held -> 0,2,0,2.
        do_reset();
        req = 4'b0101;
        for (int n = 0; n < 4; n++) begin
            serve($sformatf("fair%0d", n), (n % 2) * 2, W'(1) << 126, W'(1) << ((n % 2) * 2 + 1),
                  W'(3) << ((n % 2) * 2), 1'b0, 5, 1'b0);
        end
        req = '0;

        // Reset while BUSY, then a fresh request served normally.
        step();
        step();
        op_a[1*W +: W] = W'(1) << 100;
        op_b[1*W +: W] = W'(1) << 30;
        req = 4'b0010;
        step();
        req = '0;
        step();
        chk("midreset busy_before", busy, 1'b1);
        rst_b = 1'b0;
        #1;
        chk_zero_outputs("midreset");
        step();
        step();
        rst_b = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (resp_valid != '0 || busy) seen = 1'b1;
        end
        chk("midreset no_stale", seen, 1'b0);
        op_a[3*W +: W] = W'(1) << 100;
        op_b[3*W +: W] = W'(1) << 30;
        req = 4'b1000;
        // x^130 = x^3 * (x+1) = x^4 + x^3
        serve("postreset", 3, W'(1) << 100, W'(1) << 30, W'(24), 1'b1, 5, 1'b0);

        // Multiplier never answers.
        done_en = 1'b0;
        op_a[2*W +: W] = W'(5);
        op_b[2*W +: W] = W'(7);
        step();
        req = 4'b0100;
`ifdef GF2M_ARB_TIMEOUT_EN
        serve("timeout", 2, W'(5), W'(7), W'(0), 1'b1, 11, 1'b1);
`else
        #1;
        chk("stuck gnt", gnt, W'(4'b0100));
        step();
        req  = '0;
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            step();
            if (resp_valid != '0) seen = 1'b1;
        end
        chk("stuck busy", busy, 1'b1);
        chk("stuck no_resp", seen, 1'b0);
        do_reset();
        chk("stuck recovered busy", busy, 1'b0);
`endif
        done_en = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
